// File: rtl/divide_arbiter.sv
// divide_arbiter: round-robin scheduler sharing one Newton-Raphson divider among NUMB_REQ requesters.
// Define DIVIDE_ARBITER_ZERO_BYPASS_EN to answer b==0 locally with 0xFFFF and an error flag.
module divide_arbiter #(
  parameter int NUMB_REQ    = 4,
  parameter int DATA_WD     = 8,
  parameter int NUMB_REQ_WD = $clog2(NUMB_REQ)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUMB_REQ-1:0]         req_val_i,
  input  logic [NUMB_REQ*DATA_WD-1:0] req_dat_a_i,
  input  logic [NUMB_REQ*DATA_WD-1:0] req_dat_b_i,
  output logic [NUMB_REQ-1:0]         req_rdy_o,
  output logic                        div_val_o,
  output logic [DATA_WD-1:0]          div_dat_a_o,
  output logic [DATA_WD-1:0]          div_dat_b_o,
  input  logic                        div_val_i,
  input  logic [2*DATA_WD-1:0]        div_dat_c_i,
  output logic                        rsp_val_o,
  output logic [NUMB_REQ_WD-1:0]      rsp_id_o,
  output logic [2*DATA_WD-1:0]        rsp_dat_c_o,
  output logic                        rsp_err_o,
  output logic                        busy_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t                   r_state, w_nxt;
  logic [NUMB_REQ_WD-1:0]   r_rr_ptr, r_id, w_gnt_id, r_rsp_id;
  logic                     w_gnt_vld, w_acc, w_zero, r_rsp_val;
  logic [DATA_WD-1:0]       r_a, r_b, w_a, w_b;
  logic [2*DATA_WD-1:0]     r_rsp_dat;
  function automatic logic [NUMB_REQ_WD-1:0] wrap(input int v);
    return NUMB_REQ_WD'(v % NUMB_REQ);
  endfunction
  // scan from the highest offset down so the nearest requester after rr_ptr wins
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    for (int k = NUMB_REQ - 1; k >= 0; k--)
      if (req_val_i[wrap(int'(r_rr_ptr) + k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = wrap(int'(r_rr_ptr) + k);
      end
  end
  assign w_acc = (r_state == IDLE) && w_gnt_vld;
  assign w_a   = req_dat_a_i[w_gnt_id*DATA_WD +: DATA_WD];
  assign w_b   = req_dat_b_i[w_gnt_id*DATA_WD +: DATA_WD];
  assign req_rdy_o   = w_acc ? NUMB_REQ'(1) << w_gnt_id : '0;
  assign div_val_o   = r_state == ISSUE;
  assign div_dat_a_o = r_a;
  assign div_dat_b_o = r_b;
  assign busy_o      = r_state != IDLE;
  assign rsp_val_o   = r_rsp_val;
  assign rsp_id_o    = r_rsp_id;
  assign rsp_dat_c_o = r_rsp_dat;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = w_gnt_vld ? (w_zero ? RESP : ISSUE) : IDLE;
      ISSUE:   w_nxt = WAIT;
      WAIT:    w_nxt = div_val_i ? IDLE : WAIT;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_id      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_rsp_val <= 1'b0;
      r_rsp_id  <= '0;
      r_rsp_dat <= '0;
    end else begin
      r_state   <= w_nxt;
      r_rsp_val <= 1'b0;
      if (w_acc) begin
        r_a      <= w_a;
        r_b      <= w_b;
        r_id     <= w_gnt_id;
        r_rr_ptr <= (w_gnt_id == NUMB_REQ_WD'(NUMB_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
      end
      if (r_state == WAIT && div_val_i) begin
        r_rsp_val <= 1'b1;
        r_rsp_id  <= r_id;
        r_rsp_dat <= div_dat_c_i;
      end
      if (w_acc && w_zero) begin
        r_rsp_val <= 1'b1;
        r_rsp_id  <= w_gnt_id;
        r_rsp_dat <= '1;
      end
    end
  end
`ifdef DIVIDE_ARBITER_ZERO_BYPASS_EN
  logic r_rsp_err;
  assign w_zero    = w_b == '0;
  assign rsp_err_o = r_rsp_err;
  always_ff @(posedge clk) begin
    if (!rstn) r_rsp_err <= 1'b0;
    else if (w_acc && w_zero) r_rsp_err <= 1'b1;
    else if (r_state == WAIT && div_val_i) r_rsp_err <= 1'b0;
  end
`else
  assign w_zero    = 1'b0;
  assign rsp_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_divide_arbiter.sv
// tb_divide_arbiter: scoreboard bench with a 13-cycle behavioural divider model.
module tb_divide_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  typedef struct packed {logic [1:0] id; logic [15:0] dat; logic err;} exp_t;
  logic           clk = 1'b0, rstn = 1'b0, spur = 1'b0;
  logic [N-1:0]   req_val_i = '0, req_rdy_o, acc;
  logic [N*W-1:0] req_dat_a_i = '0, req_dat_b_i = '0;
  logic           div_val_o, div_val_i, rsp_val_o, rsp_err_o, busy_o;
  logic [W-1:0]   div_dat_a_o, div_dat_b_o;
  logic [2*W-1:0] div_dat_c_i, rsp_dat_c_o;
  logic [1:0]     rsp_id_o;
  logic [3:0]     cnt;
  exp_t           sb[$];
  exp_t           mon_e;
  int             n_err = 0, n_chk = 0, cyc = 0;
  int             times[$];
  always #5 clk = ~clk;
  divide_arbiter #(.NUMB_REQ(N), .DATA_WD(W)) dut (
    .clk(clk), .rstn(rstn), .req_val_i(req_val_i), .req_dat_a_i(req_dat_a_i),
    .req_dat_b_i(req_dat_b_i), .req_rdy_o(req_rdy_o), .div_val_o(div_val_o),
    .div_dat_a_o(div_dat_a_o), .div_dat_b_o(div_dat_b_o), .div_val_i(div_val_i),
    .div_dat_c_i(div_dat_c_i), .rsp_val_o(rsp_val_o), .rsp_id_o(rsp_id_o),
    .rsp_dat_c_o(rsp_dat_c_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
  );
  // divider model: result valid 13 cycles after the start pulse, operands read at that point
  function automatic logic [15:0] quot(input logic [7:0] a, input logic [7:0] b);
    return (b == 8'd0) ? 16'hFFFF : 16'({a, 8'h00} / {8'h00, b});
  endfunction
  always @(posedge clk)
    if (!rstn) cnt <= 4'd0;
    else if (div_val_o) cnt <= 4'd13;
    else if (cnt != 4'd0) cnt <= cnt - 4'd1;
  assign div_val_i   = (cnt == 4'd1) | spur;
  assign div_dat_c_i = quot(div_dat_a_o, div_dat_b_o);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (rstn && rsp_val_o) begin
      if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("rsp_id", rsp_id_o, mon_e.id);
        chk("rsp_dat", rsp_dat_c_o, mon_e.dat);
        chk("rsp_err", rsp_err_o, mon_e.err);
      end
    end
  task automatic step();
    @(negedge clk);
    acc = req_val_i & req_rdy_o;
    @(posedge clk);
    #1;
    req_val_i = req_val_i & ~acc;
    cyc++;
  endtask
  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask
  task automatic post(input int i, input logic [7:0] a, input logic [7:0] b);
    req_val_i[i] = 1'b1;
    req_dat_a_i[i*W +: W] = a;
    req_dat_b_i[i*W +: W] = b;
  endtask
  task automatic push(input logic [1:0] id, input logic [15:0] d, input logic err);
    sb.push_back({id, d, err});
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    req_val_i = '0;
    steps(2);
    rstn = 1'b1;
    sb.delete();
  endtask
  task automatic drain();
    for (int k = 0; k < 120 && sb.size() != 0; k++) step();
    chk("drain", sb.size(), 0);
  endtask
  initial begin
    do_reset();
    chk("rst_busy", busy_o, 0);
    chk("rst_rsp_val", rsp_val_o, 0);
    chk("rst_rdy", req_rdy_o, 0);
    chk("rst_div_val", div_val_o, 0);
    chk("rst_div_a", div_dat_a_o, 0);
    chk("rst_rsp_dat", rsp_dat_c_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    // single request, exact latency
    post(0, 8'd6, 8'd3);
    push(2'd0, 16'h0200, 1'b0);
    #1 chk("t1_rdy", req_rdy_o, 4'b0001);
    step();
    chk("t1_div_val", div_val_o, 1);
    chk("t1_div_a", div_dat_a_o, 6);
    chk("t1_div_b", div_dat_b_o, 3);
    steps(13);
    chk("t1_rsp_early", rsp_val_o, 0);
    step();
    chk("t1_rsp_val", rsp_val_o, 1);
    step();
    chk("t1_rsp_pulse", rsp_val_o, 0);
    chk("t1_hold_dat", rsp_dat_c_o, 16'h0200);
    // all four at once: round-robin order and 15-cycle spacing
    do_reset();
    for (int i = 0; i < N; i++) begin
      post(i, 8'd1, 8'd2);
      push(2'(i), 16'h0080, 1'b0);
    end
    for (int k = 1; k <= 70; k++) begin
      step();
      if (rsp_val_o) times.push_back(k);
    end
    chk("t2_rsp_count", times.size(), 4);
    for (int i = 0; i < times.size() && i < 4; i++) chk("t2_rsp_cycle", times[i], 15 * (i + 1));
    drain();
    // pointer after grant to 2 favours 3 over 1
    do_reset();
    post(2, 8'd10, 8'd4);
    push(2'd2, 16'h0280, 1'b0);
    step();
    post(1, 8'd255, 8'd1);
    post(3, 8'd7, 8'd2);
    push(2'd3, 16'h0380, 1'b0);
    push(2'd1, 16'hFF00, 1'b0);
    #1 chk("t3_rdy_busy", req_rdy_o, 0);
    drain();
    // spurious divider valid in IDLE
    spur = 1'b1;
    step();
    spur = 1'b0;
    chk("spur_rsp", rsp_val_o, 0);
    chk("spur_busy", busy_o, 0);
    // reset in WAIT drops the request
    post(0, 8'd9, 8'd3);
    steps(8);
    chk("t4_in_wait", busy_o, 1);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("t4_busy", busy_o, 0);
    chk("t4_rsp", rsp_val_o, 0);
    times.delete();
    for (int k = 0; k < 20; k++) begin
      step();
      if (rsp_val_o) times.push_back(k);
    end
    chk("t4_no_rsp", times.size(), 0);
    post(0, 8'd8, 8'd4);
    push(2'd0, 16'h0200, 1'b0);
    steps(14);
    chk("t4_rsp_early", rsp_val_o, 0);
    step();
    chk("t4_rsp_val", rsp_val_o, 1);
    drain();
    // divide by zero
    post(1, 8'd5, 8'd0);
`ifdef DIVIDE_ARBITER_ZERO_BYPASS_EN
    push(2'd1, 16'hFFFF, 1'b1);
    #1 chk("t5_rdy", req_rdy_o, 4'b0010);
    step();
    chk("t5_rsp_val", rsp_val_o, 1);
    chk("t5_div_val", div_val_o, 0);
    step();
    chk("t5_div_val2", div_val_o, 0);
`else
    push(2'd1, 16'hFFFF, 1'b0);
    #1 chk("t5_rdy", req_rdy_o, 4'b0010);
    step();
    chk("t5_div_val", div_val_o, 1);
`endif
    drain();
    // operand change during WAIT must not reach the divider
    post(3, 8'd200, 8'd5);
    push(2'd3, 16'h2800, 1'b0);
    steps(5);
    req_dat_a_i[3*W +: W] = 8'd1;
    req_dat_b_i[3*W +: W] = 8'd7;
    #1 chk("t6_div_b", div_dat_b_o, 5);
    chk("t6_div_a", div_dat_a_o, 200);
    drain();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
